// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: movement tick, IDLE/SERVE/PLAY/POINT/OVER flow and scoring.
// Optional pause support is compiled in with `define PONG_PAUSE_EN.
module pong_game_ctrl #(
  parameter int TICK_DIV    = 50000,
  parameter int SERVE_TICKS = 60,
  parameter int WIN_SCORE   = 9,
  parameter int SCORE_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               miss_left,
  input  logic               miss_right,
  input  logic               pause,
  output logic               tick,
  output logic               ball_move_en,
  output logic               ball_reset,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_player,
  output logic [SCORE_W-1:0] score_opp,
  output logic               game_over,
  output logic [2:0]         state
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
  logic               tick_q, tick_d;
  logic [SW-1:0]      serve_cnt_q, serve_cnt_d;
  logic               start_q;
  logic [SCORE_W-1:0] score_p_q, score_p_d;
  logic [SCORE_W-1:0] score_o_q, score_o_d;
  logic               dir_q, dir_d;
  logic               ball_reset_q, ball_reset_d;
  logic               move_q, move_d;
  logic               over_q, over_d;
  logic               start_pulse;
  logic               pause_req;
  logic               paused;

`ifdef PONG_PAUSE_EN
  assign pause_req = pause;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign pause_req    = 1'b0;
`endif

  assign start_pulse = start & ~start_q;
  assign paused      = pause_req & ((state_q == S_SERVE) | (state_q == S_PLAY));

  always_comb begin
    tick_d      = (tick_cnt_q == TW'(TICK_DIV - 1));
    tick_cnt_d  = tick_d ? '0 : tick_cnt_q + TW'(1);
    state_d     = state_q;
    serve_cnt_d = serve_cnt_q;
    score_p_d   = score_p_q;
    score_o_d   = score_o_q;
    dir_d       = dir_q;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_pulse) begin
          state_d   = S_SERVE;
          score_p_d = '0;
          score_o_d = '0;
          dir_d     = 1'b1;
        end
      end
      S_SERVE: begin
        // tick_q is the internal movement strobe, one cycle behind the counter wrap
        if (tick_q && !paused) begin
          if (serve_cnt_q == SW'(SERVE_TICKS - 1)) state_d = S_PLAY;
          else serve_cnt_d = serve_cnt_q + SW'(1);
        end
      end
      S_PLAY: begin
        if (!paused) begin
          if (miss_left && !miss_right) begin
            score_o_d = score_o_q + SCORE_W'(1);
            dir_d     = 1'b0;
            state_d   = S_POINT;
          end else if (miss_right && !miss_left) begin
            score_p_d = score_p_q + SCORE_W'(1);
            dir_d     = 1'b1;
            state_d   = S_POINT;
          end else if (miss_left && miss_right) begin
            state_d = S_POINT;
          end
        end
      end
      S_POINT: begin
        if ((score_p_q == SCORE_W'(WIN_SCORE)) || (score_o_q == SCORE_W'(WIN_SCORE)))
          state_d = S_OVER;
        else
          state_d = S_SERVE;
      end
      default: state_d = S_IDLE;
    endcase

    ball_reset_d = (state_d == S_SERVE) && (state_q != S_SERVE);
    if (ball_reset_d) serve_cnt_d = '0;
    // Registered in parallel with tick_q so both strobes share the same cycle
    move_d = tick_d && (state_d == S_PLAY) && !paused;
    over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      tick_q       <= 1'b0;
      serve_cnt_q  <= '0;
      start_q      <= 1'b0;
      score_p_q    <= '0;
      score_o_q    <= '0;
      dir_q        <= 1'b1;
      ball_reset_q <= 1'b0;
      move_q       <= 1'b0;
      over_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      tick_q       <= tick_d;
      serve_cnt_q  <= serve_cnt_d;
      start_q      <= start;
      score_p_q    <= score_p_d;
      score_o_q    <= score_o_d;
      dir_q        <= dir_d;
      ball_reset_q <= ball_reset_d;
      move_q       <= move_d;
      over_q       <= over_d;
    end
  end

  assign tick         = tick_q;
  assign ball_move_en = move_q;
  assign ball_reset   = ball_reset_q;
  assign serve_dir    = dir_q;
  assign score_player = score_p_q;
  assign score_opp    = score_o_q;
  assign game_over    = over_q;
  assign state        = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed game scenarios plus random play, checked
// every cycle against a rule-level game model.
module tb_pong_game_ctrl;
  localparam int TICK_DIV    = 4;
  localparam int SERVE_TICKS = 2;
  localparam int WIN_SCORE   = 3;
  localparam int SCORE_W     = 4;
`ifdef PONG_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, miss_left, miss_right, pause;
  logic tick, ball_move_en, ball_reset, serve_dir, game_over;
  logic [SCORE_W-1:0] score_player, score_opp;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  // Game model: plain integers describing the game at rule level
  int cyc, m_state, m_serve_ticks, m_sp, m_so;
  bit m_dir, m_prev_start, m_tick, m_move, m_ball_reset, m_over;

  pong_game_ctrl #(
    .TICK_DIV(TICK_DIV), .SERVE_TICKS(SERVE_TICKS),
    .WIN_SCORE(WIN_SCORE), .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .miss_left(miss_left),
    .miss_right(miss_right), .pause(pause), .tick(tick),
    .ball_move_en(ball_move_en), .ball_reset(ball_reset), .serve_dir(serve_dir),
    .score_player(score_player), .score_opp(score_opp),
    .game_over(game_over), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
      end
  endtask

  task automatic model_edge();
    bit old_tick, pulse, held;
    int old_state;
    if (rst) begin
      cyc = 0; m_state = 0; m_serve_ticks = 0; m_sp = 0; m_so = 0;
      m_dir = 1'b1; m_prev_start = 1'b0; m_tick = 1'b0; m_move = 1'b0;
      m_ball_reset = 1'b0; m_over = 1'b0;
      return;
    end
    old_tick  = m_tick;
    old_state = m_state;
    pulse     = start && !m_prev_start;
    held      = PAUSE_EN && pause;
    case (old_state)
      0, 4: if (pulse) begin m_state = 1; m_sp = 0; m_so = 0; m_dir = 1'b1; end
      1: if (old_tick && !held) begin
           m_serve_ticks++;
           if (m_serve_ticks == SERVE_TICKS) m_state = 2;
         end
      2: if (!held) begin
           if (miss_left && !miss_right) begin m_so++; m_dir = 1'b0; m_state = 3; end
           else if (miss_right && !miss_left) begin m_sp++; m_dir = 1'b1; m_state = 3; end
           else if (miss_left && miss_right) m_state = 3;
         end
      default: m_state = (m_sp == WIN_SCORE || m_so == WIN_SCORE) ? 4 : 1;
    endcase
    m_ball_reset = (m_state == 1) && (old_state != 1);
    if (m_ball_reset) m_serve_ticks = 0;
    m_prev_start = start;
    cyc++;
    m_tick = (cyc % TICK_DIV) == 0;
    m_move = m_tick && (m_state == 2) && !held;
    m_over = (m_state == 4);
  endtask

  task automatic check_all();
    chk("state", 8'(state), 8'(m_state));
    chk("tick", 8'(tick), 8'(m_tick));
    chk("ball_move_en", 8'(ball_move_en), 8'(m_move));
    chk("ball_reset", 8'(ball_reset), 8'(m_ball_reset));
    chk("serve_dir", 8'(serve_dir), 8'(m_dir));
    chk("score_player", 8'(score_player), 8'(m_sp));
    chk("score_opp", 8'(score_opp), 8'(m_so));
    chk("game_over", 8'(game_over), 8'(m_over));
  endtask

  task automatic step(input bit r, input bit st, input bit ml, input bit mr, input bit pz);
    rst = r; start = st; miss_left = ml; miss_right = mr; pause = pz;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic wait_play();
    for (int i = 0; i < 64 && m_state != 2; i++) step(0, 0, 0, 0, 0);
    chk("reach_play", 8'(state), 8'd2);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; miss_left = 1'b0; miss_right = 1'b0; pause = 1'b0;
    cyc = 0;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);

    // Idle with stray misses: ticks every 4 cycles, nothing else moves
    for (int i = 0; i < 20; i++)
      step(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);

    // Start held high: exactly one serve, then play
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0);
    wait_play();
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);

    // Opponent misses
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);

    // Simultaneous misses replay the point
    wait_play();
    step(0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);

    // Player loses three rallies -> game over
    for (int k = 0; k < 3; k++) begin
      wait_play();
      step(0, 0, 1, 0, 0);
    end
    for (int i = 0; i < 8; i++)
      step(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Reset mid-play with score_player at 2
    for (int k = 0; k < 2; k++) begin
      wait_play();
      step(0, 0, 0, 1, 0);
    end
    wait_play();
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);

    // Pause during play
    step(0, 1, 0, 0, 0);
    wait_play();
    for (int i = 0; i < 12; i++) step(0, 0, 1'($urandom_range(0, 1)), 0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0);

    // Random play
    for (int i = 0; i < 1500; i++)
      step(1'($urandom_range(0, 499) == 0),
           1'($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 11) == 0),
           1'($urandom_range(0, 11) == 0),
           1'($urandom_range(0, 5) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
